isr_controller: RTL and testbench

- Clocked, parametrised in-service register for the PIC interrupt path; successor to the 8-line combinational ISR.
- Sits between the priority resolver and the data-bus buffer/control logic.
- Tracks in-service levels across the two-pulse INTA sequence, drives the vector, and executes every OCW2 command: non-specific/specific EOI, rotate-on-EOI, rotate-in-AEOI set/clear, set-priority.
- Keeps a rotating priority base that the priority resolver consumes.

---
 rtl/pic_pkg.sv | 20 ++
 rtl/isr_rot_find.sv | 35 +++
 rtl/isr_controller.sv | 172 +++++++++++++++++
 tb/tb_isr_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared definitions for the PIC interrupt path.
//   - OCW2 opcodes, encoded as OCW2[7:5] = {R, SL, EOI}
//   - In-service FSM state encoding
package pic_pkg;

    localparam logic [2:0] OP_ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] OP_NS_EOI       = 3'b001;
    localparam logic [2:0] OP_NOP          = 3'b010;
    localparam logic [2:0] OP_SP_EOI       = 3'b011;
    localparam logic [2:0] OP_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] OP_ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] OP_SET_PRIO     = 3'b110;
    localparam logic [2:0] OP_ROT_SP_EOI   = 3'b111;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_ACK2 = 1'b1
    } isr_state_e;

endpackage

// File: rtl/isr_rot_find.sv
// Circular first-set finder: returns the first set bit of vec, scanning
// upward from base and wrapping at NUM_IRQ-1 -> 0. Purely combinational;
// shared with the priority resolver.
//   vec   : candidate bit vector
//   base  : level at which the scan starts (highest priority)
//   found : any bit set
//   index : first set level at or circularly above base
module isr_rot_find #(
    parameter  int NUM_IRQ = 8,
    localparam int IDX_W   = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] vec,
    input  logic [IDX_W-1:0]   base,
    output logic               found,
    output logic [IDX_W-1:0]   index
);

    logic [IDX_W-1:0] k;

    // Scan from the farthest offset down to offset 0 so the last hit
    // assigned is the closest one to base; no early exit needed.
    always_comb begin
        found = 1'b0;
        index = '0;
        k     = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            k = base + IDX_W'(i);
            if (vec[k]) begin
                found = 1'b1;
                index = k;
            end
        end
    end

endmodule

// File: rtl/isr_controller.sv
// Clocked in-service register for the PIC interrupt path.
// Tracks in-service levels across the two-pulse INTA sequence, issues the
// vector, executes OCW2 commands and keeps the rotating priority base.
//   clk, rst_n                : clock, async active-low reset
//   ack_valid/ack_index       : first INTA, resolver winner
//   ack2                      : second INTA
//   vector_base               : ICW2 (upper VEC_W-IDX_W bits used)
//   aeoi_en                   : ICW4 AEOI bit
//   cmd_valid/cmd_op/cmd_level: OCW2 write
//   isr_out, priority_base    : in-service register, highest-priority level
//   vector_out/vector_valid   : vector and its one-cycle strobe
//   eoi_pulse/eoi_index       : a bit was cleared, and which one
//   busy                      : between first and second INTA
module isr_controller
    import pic_pkg::*;
#(
    parameter  int NUM_IRQ = 8,
    parameter  int VEC_W   = 8,
    localparam int IDX_W   = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ack_valid,
    input  logic [IDX_W-1:0]   ack_index,
    input  logic               ack2,
    input  logic [VEC_W-1:0]   vector_base,
    input  logic               aeoi_en,
    input  logic               cmd_valid,
    input  logic [2:0]         cmd_op,
    input  logic [IDX_W-1:0]   cmd_level,
    output logic [NUM_IRQ-1:0] isr_out,
    output logic [IDX_W-1:0]   priority_base,
    output logic [VEC_W-1:0]   vector_out,
    output logic               vector_valid,
    output logic               eoi_pulse,
    output logic [IDX_W-1:0]   eoi_index,
    output logic               busy
);

    localparam logic [VEC_W-1:0] IDX_MASK = VEC_W'(NUM_IRQ - 1);
    localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

    isr_state_e         state_q, state_d;
    logic [NUM_IRQ-1:0] isr_q, isr_d, set_mask, clr_mask;
    logic [IDX_W-1:0]   pb_q, pb_d, cap_q, cap_d, eidx_q, eidx_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic               rot_q, rot_d, vv_q, vv_d, eoi_q, eoi_d, busy_q, busy_d;
    logic               ns_found, ocw_hit;
    logic [IDX_W-1:0]   ns_idx, ocw_idx;

    function automatic logic [VEC_W-1:0] vec_of(input logic [VEC_W-1:0] vb,
                                                input logic [IDX_W-1:0] idx);
        return (vb & ~IDX_MASK) | VEC_W'(idx);
    endfunction

    // Non-specific EOI target, scanned on the pre-edge ISR.
    isr_rot_find #(.NUM_IRQ(NUM_IRQ)) u_find (
        .vec   (isr_q),
        .base  (pb_q),
        .found (ns_found),
        .index (ns_idx)
    );

    always_comb begin
        state_d  = state_q;
        cap_d    = cap_q;
        pb_d     = pb_q;
        rot_d    = rot_q;
        vec_d    = vec_q;
        vv_d     = 1'b0;
        eoi_d    = 1'b0;
        eidx_d   = eidx_q;
        set_mask = '0;
        clr_mask = '0;
        ocw_hit  = 1'b0;
        ocw_idx  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (ack_valid) begin
                    set_mask[ack_index] = 1'b1;
                    cap_d               = ack_index;
                    state_d             = ST_WAIT_ACK2;
                end else if (ack2) begin
                    // Spurious acknowledge: report the lowest-priority level.
                    vec_d = vec_of(vector_base, IDX_W'(NUM_IRQ - 1));
                    vv_d  = 1'b1;
                end
            end
            ST_WAIT_ACK2: begin
                if (ack2) begin
                    vec_d   = vec_of(vector_base, cap_q);
                    vv_d    = 1'b1;
                    state_d = ST_IDLE;
                    // Gate on the bit still being set: an OCW2 EOI during the
                    // wait may already have retired it.
                    if (aeoi_en && isr_q[cap_q]) begin
                        clr_mask[cap_q] = 1'b1;
                        eoi_d           = 1'b1;
                        eidx_d          = cap_q;
                        if (rot_q) pb_d = cap_q + ONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (cmd_valid) begin
            unique case (cmd_op)
                OP_NS_EOI, OP_ROT_NS_EOI: begin
                    ocw_hit = ns_found;
                    ocw_idx = ns_idx;
                end
                OP_SP_EOI, OP_ROT_SP_EOI: begin
                    ocw_hit = isr_q[cmd_level];
                    ocw_idx = cmd_level;
                end
                OP_SET_PRIO:     pb_d  = cmd_level + ONE;
                OP_ROT_AEOI_SET: rot_d = 1'b1;
                OP_ROT_AEOI_CLR: rot_d = 1'b0;
                default:         ;
            endcase
        end

        // OCW2 EOI overrides the AEOI report and rotation; both bits clear.
        if (ocw_hit) begin
            clr_mask[ocw_idx] = 1'b1;
            eoi_d             = 1'b1;
            eidx_d            = ocw_idx;
            if (cmd_op[2]) pb_d = ocw_idx + ONE;
        end

        // A set and clear of the same bit in one cycle: the set wins.
        isr_d  = (isr_q & ~clr_mask) | set_mask;
        busy_d = (state_d == ST_WAIT_ACK2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            isr_q   <= '0;
            pb_q    <= '0;
            cap_q   <= '0;
            rot_q   <= 1'b0;
            vec_q   <= '0;
            vv_q    <= 1'b0;
            eoi_q   <= 1'b0;
            eidx_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            isr_q   <= isr_d;
            pb_q    <= pb_d;
            cap_q   <= cap_d;
            rot_q   <= rot_d;
            vec_q   <= vec_d;
            vv_q    <= vv_d;
            eoi_q   <= eoi_d;
            eidx_q  <= eidx_d;
            busy_q  <= busy_d;
        end
    end

    assign isr_out       = isr_q;
    assign priority_base = pb_q;
    assign vector_out    = vec_q;
    assign vector_valid  = vv_q;
    assign eoi_pulse     = eoi_q;
    assign eoi_index     = eidx_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_isr_controller.sv
// Directed bench for isr_controller: an 8-level instance exercised through
// INTA sequences and OCW2 commands, with vectors and EOI strobes checked
// against expectation queues, plus a 16-level instance for the basic flow.
module tb_isr_controller;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 8-level instance
    logic       ack_valid, ack2, aeoi_en, cmd_valid;
    logic [2:0] ack_index, cmd_op, cmd_level;
    logic [7:0] vector_base;
    logic [7:0] isr_out, vector_out;
    logic [2:0] priority_base, eoi_index;
    logic       vector_valid, eoi_pulse, busy;

    // 16-level instance
    logic        a16_valid, a16_ack2, aeoi16, cmd16_valid;
    logic [3:0]  a16_index, cmd16_level, pb16, eidx16;
    logic [2:0]  cmd16_op;
    logic [7:0]  vb16, vec16;
    logic [15:0] isr16;
    logic        vv16, eoi16, busy16;

    isr_controller #(.NUM_IRQ(8), .VEC_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .ack_valid(ack_valid), .ack_index(ack_index), .ack2(ack2),
        .vector_base(vector_base), .aeoi_en(aeoi_en),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_level(cmd_level),
        .isr_out(isr_out), .priority_base(priority_base),
        .vector_out(vector_out), .vector_valid(vector_valid),
        .eoi_pulse(eoi_pulse), .eoi_index(eoi_index), .busy(busy)
    );

    isr_controller #(.NUM_IRQ(16), .VEC_W(8)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .ack_valid(a16_valid), .ack_index(a16_index), .ack2(a16_ack2),
        .vector_base(vb16), .aeoi_en(aeoi16),
        .cmd_valid(cmd16_valid), .cmd_op(cmd16_op), .cmd_level(cmd16_level),
        .isr_out(isr16), .priority_base(pb16),
        .vector_out(vec16), .vector_valid(vv16),
        .eoi_pulse(eoi16), .eoi_index(eidx16), .busy(busy16)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_vec[$];
    logic [2:0] exp_eoi[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cmd(input logic [2:0] op, input logic [2:0] lvl);
        cmd_valid = 1'b1; cmd_op = op; cmd_level = lvl;
    endtask

    task automatic idle_inputs();
        ack_valid = 1'b0; ack2 = 1'b0; cmd_valid = 1'b0;
        a16_valid = 1'b0; a16_ack2 = 1'b0; cmd16_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        ack_index = '0; cmd_op = '0; cmd_level = '0;
        vector_base = 8'h40; aeoi_en = 1'b0;
        a16_index = '0; cmd16_op = '0; cmd16_level = '0; vb16 = 8'h80; aeoi16 = 1'b0;

        // Scoreboard monitor: vector and EOI strobes of the 8-level DUT.
        fork
            forever begin
                @(negedge clk);
                if (vector_valid === 1'b1) begin
                    if (exp_vec.size() == 0) chk("vec_unexpected", 32'(vector_valid), 32'h0);
                    else chk("vector_out", 32'(vector_out), 32'(exp_vec.pop_front()));
                end
                if (eoi_pulse === 1'b1) begin
                    if (exp_eoi.size() == 0) chk("eoi_unexpected", 32'(eoi_pulse), 32'h0);
                    else chk("eoi_index", 32'(eoi_index), 32'(exp_eoi.pop_front()));
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #2;
        chk("rst_isr", 32'(isr_out), 32'h0);
        chk("rst_pb", 32'(priority_base), 32'h0);
        chk("rst_vec", 32'(vector_out), 32'h0);
        chk("rst_vv", 32'(vector_valid), 32'h0);
        chk("rst_eoi", 32'(eoi_pulse), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic sequence
        ack_valid = 1'b1; ack_index = 3'd3;
        tick(); idle_inputs();
        chk("basic_isr", 32'(isr_out), 32'h08);
        chk("basic_busy", 32'(busy), 32'h1);
        ack2 = 1'b1; exp_vec.push_back(8'h43);
        tick(); idle_inputs();
        chk("basic_vv", 32'(vector_valid), 32'h1);
        chk("basic_busy_off", 32'(busy), 32'h0);
        tick();
        chk("basic_vv_onecycle", 32'(vector_valid), 32'h0);
        cmd(3'b001, 3'd0); exp_eoi.push_back(3'd3);
        tick(); idle_inputs();
        chk("basic_eoi_isr", 32'(isr_out), 32'h00);

        // Nested non-specific EOI with rotation
        cmd(3'b110, 3'd3);
        tick(); idle_inputs();
        chk("set_prio_4", 32'(priority_base), 32'h4);
        ack_valid = 1'b1; ack_index = 3'd2;
        tick(); idle_inputs();
        ack2 = 1'b1; exp_vec.push_back(8'h42);
        tick(); idle_inputs();
        ack_valid = 1'b1; ack_index = 3'd5;
        tick(); idle_inputs();
        ack2 = 1'b1; exp_vec.push_back(8'h45);
        tick(); idle_inputs();
        chk("nest_isr", 32'(isr_out), 32'h24);
        cmd(3'b101, 3'd0); exp_eoi.push_back(3'd5);
        tick(); idle_inputs();
        chk("rot_ns_isr", 32'(isr_out), 32'h04);
        chk("rot_ns_pb", 32'(priority_base), 32'h6);
        cmd(3'b011, 3'd2); exp_eoi.push_back(3'd2);
        tick(); idle_inputs();
        chk("sp_eoi_isr", 32'(isr_out), 32'h00);

        // AEOI with rotate, wrapping 7 -> 0
        aeoi_en = 1'b1;
        cmd(3'b100, 3'd0);
        tick(); idle_inputs();
        ack_valid = 1'b1; ack_index = 3'd7;
        tick(); idle_inputs();
        chk("aeoi_set", 32'(isr_out), 32'h80);
        ack2 = 1'b1; exp_vec.push_back(8'h47); exp_eoi.push_back(3'd7);
        tick(); idle_inputs();
        chk("aeoi_isr", 32'(isr_out), 32'h00);
        chk("aeoi_pb_wrap", 32'(priority_base), 32'h0);
        aeoi_en = 1'b0;
        cmd(3'b000, 3'd0);
        tick(); idle_inputs();

        // Spurious acknowledge, then EOI on a clear bit
        vector_base = 8'h08;
        ack2 = 1'b1; exp_vec.push_back(8'h0F);
        tick(); idle_inputs();
        chk("spur_isr", 32'(isr_out), 32'h00);
        chk("spur_busy", 32'(busy), 32'h0);
        cmd(3'b011, 3'd4);
        tick(); idle_inputs();
        chk("noop_eoi_pulse", 32'(eoi_pulse), 32'h0);

        // Collision: set and specific EOI on the same bit
        ack_valid = 1'b1; ack_index = 3'd1;
        tick(); idle_inputs();
        ack2 = 1'b1; exp_vec.push_back(8'h09);
        tick(); idle_inputs();
        ack_valid = 1'b1; ack_index = 3'd1;
        cmd(3'b011, 3'd1); exp_eoi.push_back(3'd1);
        tick(); idle_inputs();
        chk("coll_isr", 32'(isr_out), 32'h02);
        chk("coll_pulse", 32'(eoi_pulse), 32'h1);
        chk("coll_busy", 32'(busy), 32'h1);
        cmd(3'b110, 3'd2);
        tick(); idle_inputs();
        chk("prio_3", 32'(priority_base), 32'h3);
        cmd(3'b110, 3'd7);
        tick(); idle_inputs();
        chk("prio_wrap", 32'(priority_base), 32'h0);
        ack2 = 1'b1; exp_vec.push_back(8'h09);
        tick(); idle_inputs();
        cmd(3'b011, 3'd1); exp_eoi.push_back(3'd1);
        tick(); idle_inputs();
        chk("coll_clean", 32'(isr_out), 32'h00);

        // Async reset while waiting for the second INTA
        cmd(3'b110, 3'd4);
        tick(); idle_inputs();
        ack_valid = 1'b1; ack_index = 3'd5;
        tick(); idle_inputs();
        chk("pre_rst_busy", 32'(busy), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_isr", 32'(isr_out), 32'h0);
        chk("arst_pb", 32'(priority_base), 32'h0);
        chk("arst_vec", 32'(vector_out), 32'h0);
        chk("arst_eidx", 32'(eoi_index), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_vv", 32'(vector_valid), 32'h0);
        chk("post_rst_busy", 32'(busy), 32'h0);

        // 16-level basic sequence
        a16_valid = 1'b1; a16_index = 4'd12;
        tick(); idle_inputs();
        chk("n16_isr", 32'(isr16), 32'h1000);
        chk("n16_busy", 32'(busy16), 32'h1);
        a16_ack2 = 1'b1;
        tick(); idle_inputs();
        chk("n16_vv", 32'(vv16), 32'h1);
        chk("n16_vec", 32'(vec16), 32'h8C);
        cmd16_valid = 1'b1; cmd16_op = 3'b001;
        tick(); idle_inputs();
        chk("n16_eoi_isr", 32'(isr16), 32'h0);
        chk("n16_eoi_pulse", 32'(eoi16), 32'h1);
        chk("n16_eoi_idx", 32'(eidx16), 32'hC);

        tick();
        chk("vec_queue_left", 32'(exp_vec.size()), 32'h0);
        chk("eoi_queue_left", 32'(exp_eoi.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
